// File: rtl/fp_pkg.sv
`default_nettype none
//==============================================================================
// Module   : fp_pkg
// Brief    : Shared FPU types and width-generic helpers for IEEE-754 datapaths.
// Revision : 1.0 - initial release
//==============================================================================
package fp_pkg;

    localparam int EXPW16  = 5;
    localparam int FRACW16 = 10;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    function automatic int fp_bias(input int expw);
        return (1 << (expw - 1)) - 1;
    endfunction

    // Canonical quiet NaN, right-aligned in 64 bits: {0, all-ones, 1, zeros}.
    function automatic logic [63:0] fp_qnan(input int expw, input int fracw);
        logic [63:0] v;
        v = ((64'd1 << expw) - 64'd1) << fracw;
        v = v | (64'd1 << (fracw - 1));
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_norm_round.sv
`default_nettype none
//==============================================================================
// Module   : fp_norm_round
// Brief    : Combinational normaliser and round-to-nearest-even rounder.
// Revision : 1.0 - initial release
//==============================================================================
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int EXPW  = EXPW16,
    parameter int FRACW = FRACW16
) (
    input  logic [FRACW+4:0]    i_sum,
    input  logic [EXPW-1:0]     i_exp,
    input  logic                i_sign,
    output logic [EXPW+FRACW:0] o_result,
    output fp_flags_t           o_flags
);
    localparam int c_NW = FRACW + 4;
    localparam logic [EXPW:0] c_EXPMAX = {1'b0, {EXPW{1'b1}}};

    logic [c_NW-1:0]  w_norm;
    logic [EXPW:0]    w_expN;
    logic [EXPW:0]    w_expR;
    logic [FRACW+1:0] w_rounded;
    logic [FRACW-1:0] w_frac;
    logic             w_up;
    logic             w_inexact;
    int               w_lzc;
    int               w_sh;

    always_comb begin
        w_lzc = c_NW;
        for (int i = 0; i < c_NW; i++) begin
            if (i_sum[i]) w_lzc = c_NW - 1 - i;
        end
        // Left shift is capped so the exponent never drops below 1.
        w_sh = (w_lzc < int'(i_exp) - 1) ? w_lzc : int'(i_exp) - 1;

        if (i_sum[FRACW+4]) begin
            w_norm = {i_sum[FRACW+4:2], i_sum[1] | i_sum[0]};
            w_expN = {1'b0, i_exp} + (EXPW+1)'(1);
        end else begin
            w_norm = i_sum[c_NW-1:0] << w_sh;
            w_expN = (EXPW+1)'(int'(i_exp) - w_sh);
        end

        w_up      = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_inexact = |w_norm[2:0];
        w_rounded = {1'b0, w_norm[c_NW-1:3]} + (FRACW+2)'(w_up);

        // A subnormal whose rounding sets the hidden bit lands on exp=1 naturally.
        if (w_rounded[FRACW+1]) begin
            w_expR = w_expN + (EXPW+1)'(1);
            w_frac = w_rounded[FRACW:1];
        end else begin
            w_expR = w_rounded[FRACW] ? w_expN : '0;
            w_frac = w_rounded[FRACW-1:0];
        end

        o_flags = '0;
        if (w_expR >= c_EXPMAX) begin
            o_result         = {i_sign, {EXPW{1'b1}}, {FRACW{1'b0}}};
            o_flags.overflow = 1'b1;
            o_flags.inexact  = 1'b1;
        end else begin
            o_result          = {i_sign, w_expR[EXPW-1:0], w_frac};
            o_flags.inexact   = w_inexact;
            o_flags.underflow = w_inexact && (w_expR == '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_sub_pipe.sv
`default_nettype none
//==============================================================================
// Module   : fp_add_sub_pipe
// Brief    : Three-stage IEEE-754 adder/subtractor with valid/ready handshake.
// Revision : 1.0 - initial release
//==============================================================================
module fp_add_sub_pipe
    import fp_pkg::*;
#(
    parameter int EXPW  = EXPW16,
    parameter int FRACW = FRACW16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXPW+FRACW:0] op_a,
    input  logic [EXPW+FRACW:0] op_b,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EXPW+FRACW:0] result,
    output logic [3:0]          flags
);
    localparam int c_W     = 1 + EXPW + FRACW;
    localparam int c_EXTW  = FRACW + 4;
    localparam int c_MAXSH = FRACW + 3;
    localparam logic [63:0]     c_QNAN64 = fp_qnan(EXPW, FRACW);
    localparam logic [c_W-1:0]  c_QNAN   = c_QNAN64[c_W-1:0];
    localparam logic [EXPW-1:0] c_EXPMAX = {EXPW{1'b1}};
    localparam logic [EXPW-1:0] c_EXP1   = {{(EXPW-1){1'b0}}, 1'b1};

    // ---------------- stage 1: decode, specials, sort and align ----------------
    logic              w_aSign, w_bSign;
    logic [EXPW-1:0]   w_aExp, w_bExp;
    logic [FRACW-1:0]  w_aFrac, w_bFrac;
    logic              w_aNan, w_bNan, w_aSnan, w_bSnan, w_aInf, w_bInf, w_aZero, w_bZero;
    logic              w_swap, w_lSign;
    logic [EXPW-1:0]   w_lExp, w_sExp, w_lExpEff, w_sExpEff, w_diff;
    logic [FRACW:0]    w_lSig, w_sSig;
    logic [2*FRACW+5:0] w_shWide;
    logic [c_EXTW-1:0] w_lExt, w_sExt;
    int                w_shAmt;
    logic              w_spec, w_specInv;
    logic [c_W-1:0]    w_specRes;

    assign {w_aSign, w_aExp, w_aFrac} = op_a;
    assign {w_bExp, w_bFrac}          = op_b[c_W-2:0];
    assign w_bSign = op_b[c_W-1] ^ sub;

    always_comb begin
        w_aNan  = (w_aExp == c_EXPMAX) && (w_aFrac != '0);
        w_bNan  = (w_bExp == c_EXPMAX) && (w_bFrac != '0);
        w_aSnan = w_aNan && !w_aFrac[FRACW-1];
        w_bSnan = w_bNan && !w_bFrac[FRACW-1];
        w_aInf  = (w_aExp == c_EXPMAX) && (w_aFrac == '0);
        w_bInf  = (w_bExp == c_EXPMAX) && (w_bFrac == '0);
        w_aZero = (w_aExp == '0) && (w_aFrac == '0);
        w_bZero = (w_bExp == '0) && (w_bFrac == '0);

        w_spec    = 1'b1;
        w_specInv = w_aSnan | w_bSnan;
        w_specRes = c_QNAN;
        if (w_aNan || w_bNan) begin
            w_specRes = c_QNAN;
        end else if (w_aInf && w_bInf && (w_aSign != w_bSign)) begin
            w_specInv = 1'b1;
        end else if (w_aInf) begin
            w_specRes = {w_aSign, c_EXPMAX, {FRACW{1'b0}}};
        end else if (w_bInf) begin
            w_specRes = {w_bSign, c_EXPMAX, {FRACW{1'b0}}};
        end else if (w_aZero && w_bZero) begin
            w_specRes = {w_aSign & w_bSign, {(c_W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end

        w_swap    = {w_bExp, w_bFrac} > {w_aExp, w_aFrac};
        w_lSign   = w_swap ? w_bSign : w_aSign;
        w_lExp    = w_swap ? w_bExp : w_aExp;
        w_sExp    = w_swap ? w_aExp : w_bExp;
        w_lSig    = w_swap ? {|w_bExp, w_bFrac} : {|w_aExp, w_aFrac};
        w_sSig    = w_swap ? {|w_aExp, w_aFrac} : {|w_bExp, w_bFrac};
        w_lExpEff = (w_lExp == '0) ? c_EXP1 : w_lExp;
        w_sExpEff = (w_sExp == '0) ? c_EXP1 : w_sExp;
        w_diff    = w_lExpEff - w_sExpEff;
        w_shAmt   = (int'(w_diff) > c_MAXSH) ? c_MAXSH : int'(w_diff);
        // Low half of the wide vector collects everything shifted past R.
        w_shWide  = {w_sSig, 2'b00, {c_MAXSH{1'b0}}} >> w_shAmt;
        w_sExt    = {w_shWide[2*FRACW+5:FRACW+3], |w_shWide[FRACW+2:0]};
        w_lExt    = {w_lSig, 3'b000};
    end

    // ---------------- handshake ----------------
    logic r_s1Valid, r_s2Valid, r_s3Valid;
    logic w_load1, w_load2, w_load3;

    assign w_load3   = !r_s3Valid || out_ready;
    assign w_load2   = !r_s2Valid || w_load3;
    assign w_load1   = !r_s1Valid || w_load2;
    assign in_ready  = w_load1;
    assign out_valid = r_s3Valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s2Valid <= 1'b0;
            r_s3Valid <= 1'b0;
        end else begin
            if (w_load1) r_s1Valid <= in_valid;
            if (w_load2) r_s2Valid <= r_s1Valid;
            if (w_load3) r_s3Valid <= r_s2Valid;
        end
    end

    // ---------------- stage 2: significand add ----------------
    logic              r_s1LSign, r_s1EffSub, r_s1Spec, r_s1SpecInv;
    logic [EXPW-1:0]   r_s1Exp;
    logic [c_EXTW-1:0] r_s1LExt, r_s1SExt;
    logic [c_W-1:0]    r_s1SpecRes;
    logic [c_EXTW:0]   w_sum;
    logic              w_sumSign;

    always_comb begin
        w_sum = r_s1EffSub ? ({1'b0, r_s1LExt} - {1'b0, r_s1SExt})
                           : ({1'b0, r_s1LExt} + {1'b0, r_s1SExt});
        w_sumSign = (r_s1EffSub && (w_sum == '0)) ? 1'b0 : r_s1LSign;
    end

    logic              r_s2Sign, r_s2Spec, r_s2SpecInv;
    logic [EXPW-1:0]   r_s2Exp;
    logic [c_EXTW:0]   r_s2Sum;
    logic [c_W-1:0]    r_s2SpecRes;

    always_ff @(posedge clock) begin
        if (w_load1 && in_valid) begin
            r_s1LSign   <= w_lSign;
            r_s1EffSub  <= w_aSign != w_bSign;
            r_s1Exp     <= w_lExpEff;
            r_s1LExt    <= w_lExt;
            r_s1SExt    <= w_sExt;
            r_s1Spec    <= w_spec;
            r_s1SpecInv <= w_specInv;
            r_s1SpecRes <= w_specRes;
        end
        if (w_load2 && r_s1Valid) begin
            r_s2Sign    <= w_sumSign;
            r_s2Exp     <= r_s1Exp;
            r_s2Sum     <= w_sum;
            r_s2Spec    <= r_s1Spec;
            r_s2SpecInv <= r_s1SpecInv;
            r_s2SpecRes <= r_s1SpecRes;
        end
    end

    // ---------------- stage 3: normalise, round, output ----------------
    logic [c_W-1:0] w_nrResult;
    fp_flags_t      w_nrFlags;
    logic [c_W-1:0] r_result;
    fp_flags_t      r_flags;

    fp_norm_round #(
        .EXPW  (EXPW),
        .FRACW (FRACW)
    ) u_norm_round (
        .i_sum    (r_s2Sum),
        .i_exp    (r_s2Exp),
        .i_sign   (r_s2Sign),
        .o_result (w_nrResult),
        .o_flags  (w_nrFlags)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_load3 && r_s2Valid) begin
            if (r_s2Spec) begin
                r_result <= r_s2SpecRes;
                r_flags  <= '{invalid: r_s2SpecInv, default: 1'b0};
            end else begin
                r_result <= w_nrResult;
                r_flags  <= w_nrFlags;
            end
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_sub_pipe.sv
`default_nettype none
//==============================================================================
// Module   : tb_fp_add_sub_pipe
// Brief    : Directed self-checking bench for the binary16 add/sub pipeline.
// Revision : 1.0 - initial release
//==============================================================================
module tb_fp_add_sub_pipe;
    import fp_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] res;
        logic [3:0]  flg;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [3:0]  flags;
    int          nPass = 0;
    int          nTotal = 0;

    fp_add_sub_pipe #(
        .EXPW  (EXPW16),
        .FRACW (FRACW16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clock = ~clock;

    // Issues one operation into an idle pipe and waits for its result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [15:0] res, output logic [3:0] flg, output int lat);
        @(negedge clock);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        res = result;
        flg = flags;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        nTotal++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else nPass++;
        nTotal++; if (result !== 16'h0000) $display("FAIL reset_result: got %h want 0000", result); else nPass++;
        nTotal++; if (flags !== 4'h0) $display("FAIL reset_flags: got %b want 0000", flags); else nPass++;
        @(negedge clock);
        reset = 1'b0;
        #1;
        nTotal++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else nPass++;
    endtask

    task automatic test_arith();
        vec_t v[6];
        logic [15:0] r; logic [3:0] f; int lat;
        v = '{'{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000},
              '{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000},
              '{16'h3C01, 16'h3C00, 1'b1, 16'h1400, 4'b0000},
              '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000},
              '{16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000},
              '{16'h0000, 16'h8000, 1'b0, 16'h0000, 4'b0000}};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].a, v[i].b, v[i].s, r, f, lat);
            nTotal++; if (lat !== 3) $display("FAIL arith[%0d] latency: got %0d want 3", i, lat); else nPass++;
            nTotal++; if (r !== v[i].res) $display("FAIL arith[%0d] result: got %h want %h", i, r, v[i].res); else nPass++;
            nTotal++; if (f !== v[i].flg) $display("FAIL arith[%0d] flags: got %b want %b", i, f, v[i].flg); else nPass++;
        end
    endtask

    task automatic test_specials();
        vec_t v[5];
        logic [15:0] r; logic [3:0] f; int lat;
        v = '{'{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101},
              '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000},
              '{16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 4'b1000},
              '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000},
              '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 4'b0000}};
        for (int i = 0; i < 5; i++) begin
            run_op(v[i].a, v[i].b, v[i].s, r, f, lat);
            nTotal++; if (r !== v[i].res) $display("FAIL specials[%0d] result: got %h want %h", i, r, v[i].res); else nPass++;
            nTotal++; if (f !== v[i].flg) $display("FAIL specials[%0d] flags: got %b want %b", i, f, v[i].flg); else nPass++;
        end
    endtask

    task automatic test_rounding();
        vec_t v[6];
        logic [15:0] r; logic [3:0] f; int lat;
        v = '{'{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001},
              '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001},
              '{16'h3C00, 16'h1001, 1'b0, 16'h3C01, 4'b0001},
              '{16'h3C00, 16'h0001, 1'b0, 16'h3C00, 4'b0001},
              '{16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000},
              '{16'h0400, 16'h0001, 1'b1, 16'h03FF, 4'b0000}};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].a, v[i].b, v[i].s, r, f, lat);
            nTotal++; if (r !== v[i].res) $display("FAIL rounding[%0d] result: got %h want %h", i, r, v[i].res); else nPass++;
            nTotal++; if (f !== v[i].flg) $display("FAIL rounding[%0d] flags: got %b want %b", i, f, v[i].flg); else nPass++;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[8];
        int sendIdx = 0;
        int recvIdx = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic extra = 1'b0;
        logic [15:0] heldRes = '0;
        logic [3:0]  heldFlg = '0;
        v = '{'{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000},
              '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101},
              '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001},
              '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001},
              '{16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000},
              '{16'h0400, 16'h0001, 1'b1, 16'h03FF, 4'b0000},
              '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 4'b1000},
              '{16'h3C01, 16'h3C00, 1'b1, 16'h1400, 4'b0000}};
        while (recvIdx < 8 && cyc < 300) begin
            @(negedge clock);
            if (stalled) begin
                nTotal++;
                if (out_valid !== 1'b1 || result !== heldRes || flags !== heldFlg)
                    $display("FAIL b2b_stable: valid=%b result=%h flags=%b want 1 %h %b",
                             out_valid, result, flags, heldRes, heldFlg);
                else nPass++;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            if (sendIdx < 8) begin
                in_valid = 1'b1; op_a = v[sendIdx].a; op_b = v[sendIdx].b; sub = v[sendIdx].s;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                nTotal++;
                if (result !== v[recvIdx].res || flags !== v[recvIdx].flg)
                    $display("FAIL b2b_result[%0d]: got %h/%b want %h/%b",
                             recvIdx, result, flags, v[recvIdx].res, v[recvIdx].flg);
                else nPass++;
                recvIdx++;
            end
            if (in_valid && in_ready) sendIdx++;
            stalled = out_valid && !out_ready;
            heldRes = result;
            heldFlg = flags;
            cyc++;
        end
        nTotal++; if (recvIdx !== 8) $display("FAIL b2b_count: got %0d want 8", recvIdx); else nPass++;
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (out_valid) extra = 1'b1;
        end
        nTotal++; if (extra !== 1'b0) $display("FAIL b2b_duplicate: got out_valid after drain want none"); else nPass++;
    endtask

    task automatic test_reset_midstream();
        logic stale = 1'b0;
        @(negedge clock);
        out_ready = 1'b0; in_valid = 1'b1; op_a = 16'h3C00; op_b = 16'h3C00; sub = 1'b0;
        repeat (4) @(negedge clock);
        nTotal++; if (out_valid !== 1'b1) $display("FAIL midrst_filled: got %b want 1", out_valid); else nPass++;
        #2;
        reset = 1'b1;
        #1;
        nTotal++; if (out_valid !== 1'b0) $display("FAIL midrst_async_valid: got %b want 0", out_valid); else nPass++;
        nTotal++; if (result !== 16'h0000 || flags !== 4'h0)
            $display("FAIL midrst_outputs: got %h/%b want 0000/0000", result, flags); else nPass++;
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0; out_ready = 1'b1;
        #1;
        nTotal++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready); else nPass++;
        repeat (8) begin
            @(negedge clock);
            if (out_valid) stale = 1'b1;
        end
        nTotal++; if (stale !== 1'b0) $display("FAIL midrst_stale: got out_valid after reset want none"); else nPass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arith();
        test_specials();
        test_rounding();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_add_sub_pipe.md
# fp_add_sub_pipe

Parametrised, pipelined IEEE-754 binary floating-point adder/subtractor, and the next generation of the FPU add/sub datapath. Generalised in exponent and fraction width, it adds full special-value handling, round-to-nearest-even, exception flags and a valid/ready handshake. It sits between the FPU operand-issue logic and the result writeback, and accepts one operation per cycle when not stalled.

## Interface
- `EXPW`, default 5: exponent width; bias = 2^(EXPW-1)-1.
- `FRACW`, default 10: stored fraction width. Defaults give binary16.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operands presented.
- `in_ready`  out  1: block accepts when `in_valid && in_ready`.
- `op_a`, `op_b`  in  1+EXPW+FRACW each: operands {sign, exp, frac}.
- `sub`  in  1: 1 computes a−b; 0 computes a+b.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `result`  out  1+EXPW+FRACW: rounded result.
- `flags`  out  4: {invalid, overflow, underflow, inexact}.

## Operation
- Effective b sign is `op_b.sign ^ sub`.
- Stage 1 (sort/align):
  - Swap operands so that {exp,frac} of the larger magnitude is in "large".
  - Hidden bit is 1 for exp≠0, else 0; a subnormal uses effective exponent 1.
  - Shift the small significand right by the exponent difference into FRACW+1 bits plus guard, round and sticky (sticky = OR of all bits shifted out).
  - A shift ≥ FRACW+3 leaves only sticky.
- Stage 2 (add): add or subtract the significands according to the sign match into a FRACW+5-bit sum. Result sign is the sign of large, except an exact-zero difference gives +0.
- Stage 3 (normalise/round):
  - Carry-out: shift right 1 and increment exp; the shifted-out bit ORs into sticky.
  - Otherwise: shift left by the leading-zero count, limited so that exp does not go below 1. Result is subnormal (exp=0) if it is still unnormalised.
  - RNE: round up iff G && (R || S || LSB).
  - A round-up carry into the hidden bit increments exp; a subnormal promotes to exp=1.
- Specials, resolved in stage 1 and carried as a bypass:
  - Any NaN input → canonical qNaN {0, all-ones, 1 followed by zeros}.
  - +inf + −inf (effective) → qNaN with invalid=1; sNaN input also sets invalid.
  - A single inf → that inf.
  - (+0)+(+0) → +0; (−0)+(−0) → −0; mixed-sign zeros → +0.
- Flags:
  - overflow: the rounded exp reaches all-ones; result = ±inf; also sets inexact.
  - underflow: result is tiny (subnormal or zero) after rounding AND inexact.
  - inexact: any of G/R/S is nonzero.
  - Specials carry no flags other than invalid.

## Timing
- Three registered stages. Latency is 3 cycles from acceptance to `out_valid` when there is no stall. Throughput is 1/cycle.
- Each stage register has a valid bit. A stage loads when it is empty or its successor loads.
- `in_ready` = !s1_valid || s1_advance. This is combinational from `out_ready` through the chain; there are no skid buffers.
- With `out_ready`=0, all full stages hold their data. `result` and `flags` stay stable while `out_valid && !out_ready`.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Reset: all stage valids = 0, `out_valid`=0, `result`=0, `flags`=0. `in_ready`=1 after reset deasserts.
- Reset mid-operation discards all in-flight operations. No result is emitted for them.
- Data registers without reset are permitted except the output registers.

## Structure
- Shared package `fp_pkg`:
  - parametrised-width helpers `fp_bias`, `fp_qnan`;
  - flag struct `fp_flags_t` {invalid, overflow, underflow, inexact};
  - binary16 localparams EXPW16=5 and FRACW16=10.
- Sub-module `fp_norm_round`: combinational normaliser and RNE rounder, parametrised by EXPW/FRACW. It is reused later by mul/fma.
- Stage registers and handshake stay in the top module.

## Test plan
- 0x3C00 + 0x3C00 → 0x4000, flags 0, `out_valid` exactly 3 cycles after acceptance.
- 0x3C00 with sub=1, 0x3C00 → 0x0000 (+0). Also 0x8000 + 0x8000 → 0x8000.
- 0x7BFF + 0x7BFF → 0x7C00, flags overflow|inexact. 0x7C00 + 0xFC00 → 0x7E00, flags invalid.
- 0x3C00 + 0x1000 (2^-11, a tie) → 0x3C00 inexact. 0x3C01 + 0x1000 → 0x3C02 inexact (both cases round to even).
- 0x0001 + 0x0001 → 0x0002, flags 0. 0x0400 with sub=1, 0x0001 → 0x03FF, flags 0.
- Back-to-back stream of 8 ops with `out_ready` random 50%:
  - results arrive in order and none is lost or duplicated;
  - `result` is stable while stalled;
  - assert `reset` mid-stream → `out_valid` drops asynchronously and no stale results appear afterwards.
